// File: rtl/rgb2bayer_mosaic.sv
// Streaming RGB to Bayer re-mosaic encoder with raster framing checks.
// Two-stage pipeline: capture/flag stage, then component select stage.
module rgb2bayer_mosaic #(
    parameter int PIXSIZE = 16,
    parameter int ROW_W   = 13,
    parameter int COL_W   = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 c_en,
    input  logic [ROW_W:0]       c_rows,
    input  logic [COL_W:0]       c_cols,
    input  logic [1:0]           c_bayer_mode,
    input  logic                 frame_valid,
    input  logic                 line_valid,
    input  logic [3*PIXSIZE-1:0] pixel_data,
    input  logic                 err_clr,
    output logic                 frame_valid_o,
    output logic                 line_valid_o,
    output logic [PIXSIZE-1:0]   pixel_data_o,
    output logic                 frame_start_o,
    output logic                 line_start_o,
    output logic [1:0]           err_o
);

    localparam logic [ROW_W:0] ROW_ONE = 1;
    localparam logic [COL_W:0] COL_ONE = 1;

    logic [ROW_W:0]       c_rows_r;
    logic [COL_W:0]       c_cols_r;
    logic [1:0]           mode_r;
    logic [ROW_W:0]       row_cnt;
    logic [COL_W:0]       col_cnt;
    logic                 lv_q;
    logic                 fv_q;

    logic                 data_valid;
    logic                 col_wrap;
    logic                 row_wrap;
    logic                 line_err;
    logic                 frame_trunc;
    logic [ROW_W:0]       row_next;

    logic                 s1_v;
    logic [3*PIXSIZE-1:0] s1_pix;
    logic                 s1_row0;
    logic                 s1_col0;
    logic                 s1_first;
    logic                 s1_lstart;
    logic                 s1_last;
    logic                 s1_trunc;
    logic                 s2_last;

    logic [PIXSIZE-1:0]   comp_r;
    logic [PIXSIZE-1:0]   comp_g;
    logic [PIXSIZE-1:0]   comp_b;
    logic [1:0]           par;
    logic [PIXSIZE-1:0]   sel;

    always_comb begin
        data_valid  = frame_valid & line_valid & c_en;
        col_wrap    = (col_cnt == c_cols_r);
        row_wrap    = (row_cnt == c_rows_r);
        row_next    = row_wrap ? '0 : row_cnt + ROW_ONE;
        line_err    = c_en & lv_q & ~line_valid & frame_valid
                    & (col_cnt != '0);
        frame_trunc = c_en & fv_q & ~frame_valid
                    & ((row_cnt != '0) | (col_cnt != '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rows_r <= '0;
            c_cols_r <= '0;
            mode_r   <= '0;
        end else if (!c_en) begin
            c_rows_r <= c_rows - ROW_ONE;
            c_cols_r <= c_cols - COL_ONE;
            mode_r   <= c_bayer_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lv_q <= 1'b0;
            fv_q <= 1'b0;
        end else begin
            lv_q <= line_valid;
            fv_q <= frame_valid;
        end
    end

    // A short line closes the current row early; truncation restarts the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (!c_en || frame_trunc) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (line_err) begin
            col_cnt <= '0;
            row_cnt <= row_next;
        end else if (data_valid) begin
            if (col_wrap) begin
                col_cnt <= '0;
                row_cnt <= row_next;
            end else begin
                col_cnt <= col_cnt + COL_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= '0;
        end else begin
            err_o <= (err_o & {2{~err_clr}}) | {frame_trunc, line_err};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_pix    <= '0;
            s1_row0   <= 1'b0;
            s1_col0   <= 1'b0;
            s1_first  <= 1'b0;
            s1_lstart <= 1'b0;
            s1_last   <= 1'b0;
            s1_trunc  <= 1'b0;
        end else begin
            s1_v     <= data_valid;
            s1_trunc <= frame_trunc;
            if (data_valid) begin
                s1_pix    <= pixel_data;
                s1_row0   <= row_cnt[0];
                s1_col0   <= col_cnt[0];
                s1_first  <= (row_cnt == '0) && (col_cnt == '0);
                s1_lstart <= (col_cnt == '0);
                s1_last   <= row_wrap && col_wrap;
            end
        end
    end

    // R sits at the parity equal to the mode code, B at its complement.
    always_comb begin
        comp_r = mode_r[1] ? s1_pix[PIXSIZE-1:0]
                           : s1_pix[3*PIXSIZE-1:2*PIXSIZE];
        comp_g = s1_pix[2*PIXSIZE-1:PIXSIZE];
        comp_b = mode_r[1] ? s1_pix[3*PIXSIZE-1:2*PIXSIZE]
                           : s1_pix[PIXSIZE-1:0];
        par    = {s1_row0, s1_col0};
        sel    = comp_g;
        unique case (1'b1)
            (par == mode_r):  sel = comp_r;
            (par == ~mode_r): sel = comp_b;
            default:          sel = comp_g;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_valid_o  <= 1'b0;
            frame_start_o <= 1'b0;
            line_start_o  <= 1'b0;
            frame_valid_o <= 1'b0;
            s2_last       <= 1'b0;
            pixel_data_o  <= '0;
        end else if (!c_en) begin
            line_valid_o  <= 1'b0;
            frame_start_o <= 1'b0;
            line_start_o  <= 1'b0;
            frame_valid_o <= 1'b0;
            s2_last       <= 1'b0;
        end else begin
            line_valid_o  <= s1_v;
            frame_start_o <= s1_v & s1_first;
            line_start_o  <= s1_v & s1_lstart;
            s2_last       <= s1_v & s1_last;
            if (s1_v) begin
                pixel_data_o <= sel;
            end
            if (s1_v && s1_first) begin
                frame_valid_o <= 1'b1;
            end else if (s2_last || s1_trunc) begin
                frame_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgb2bayer_mosaic.sv
// Bench for rgb2bayer_mosaic: directed frames with random pixels,
// checked each cycle against a queue of coordinate-derived expectations.
module tb_rgb2bayer_mosaic;

    logic        clk;
    logic        rst_n;
    logic        c_en;
    logic [13:0] c_rows;
    logic [14:0] c_cols;
    logic [1:0]  c_bayer_mode;
    logic        frame_valid;
    logic        line_valid;
    logic [47:0] pixel_data;
    logic        err_clr;
    logic        frame_valid_o;
    logic        line_valid_o;
    logic [15:0] pixel_data_o;
    logic        frame_start_o;
    logic        line_start_o;
    logic [1:0]  err_o;

    rgb2bayer_mosaic dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .c_en          (c_en),
        .c_rows        (c_rows),
        .c_cols        (c_cols),
        .c_bayer_mode  (c_bayer_mode),
        .frame_valid   (frame_valid),
        .line_valid    (line_valid),
        .pixel_data    (pixel_data),
        .err_clr       (err_clr),
        .frame_valid_o (frame_valid_o),
        .line_valid_o  (line_valid_o),
        .pixel_data_o  (pixel_data_o),
        .frame_start_o (frame_start_o),
        .line_start_o  (line_start_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        bit          first;
        bit          ls;
        bit          last;
        int          due;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] seen[$];
    int          checks;
    int          errors;
    int          cyc;
    int          flush_at;
    int          fv_clr_at;
    bit          exp_fv;
    int          fs_cnt;
    int          ls_cnt;
    logic [1:0]  cur_mode;
    int          cur_rows;
    int          cur_cols;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] pick(input logic [1:0] m,
                                         input int r, input int c,
                                         input logic [15:0] rr,
                                         input logic [15:0] gg,
                                         input logic [15:0] bb);
        string pat;
        byte   ch;
        case (m)
            2'd0:    pat = "RGGB";
            2'd1:    pat = "GRBG";
            2'd2:    pat = "GBRG";
            default: pat = "BGGR";
        endcase
        ch = pat[(r % 2) * 2 + (c % 2)];
        if (ch == "R") return rr;
        if (ch == "G") return gg;
        return bb;
    endfunction

    task automatic check();
        exp_t e;
        bit   due;
        if (flush_at == cyc) begin
            expq.delete();
            exp_fv = 1'b0;
        end
        if (fv_clr_at == cyc) exp_fv = 1'b0;
        while (expq.size() > 0 && expq[0].due < cyc) begin
            chk("miss_due", expq[0].due, cyc);
            void'(expq.pop_front());
        end
        due = (expq.size() > 0) && (expq[0].due == cyc);
        chk("line_valid_o", line_valid_o, due);
        if (due) begin
            e = expq.pop_front();
            if (line_valid_o) begin
                chk("pixel_data_o", pixel_data_o, e.d);
                chk("frame_start_o", frame_start_o, e.first);
                chk("line_start_o", line_start_o, e.ls);
                seen.push_back(pixel_data_o);
                if (frame_start_o) fs_cnt++;
                if (line_start_o) ls_cnt++;
                if (e.first) exp_fv = 1'b1;
                if (e.last) fv_clr_at = cyc + 1;
            end
        end else begin
            chk("idle_starts", {frame_start_o, line_start_o}, 2'b00);
        end
        chk("frame_valid_o", frame_valid_o, exp_fv);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        check();
    endtask

    task automatic idle(input int n, input logic fv);
        for (int i = 0; i < n; i++) begin
            frame_valid = fv;
            line_valid  = 1'b0;
            pixel_data  = {$urandom(), 16'($urandom())};
            step();
        end
    endtask

    task automatic drive_px(input int r, input int c, input int kind);
        logic [15:0] rr, gg, bb;
        exp_t        e;
        int          i;
        i = r * cur_cols + c;
        case (kind)
            1: begin
                rr = 16'h1000 + 16'(i);
                gg = 16'h2000 + 16'(i);
                bb = 16'h3000 + 16'(i);
            end
            2: begin
                rr = 16'hBBBB;
                gg = 16'h5555;
                bb = 16'hAAAA;
            end
            default: begin
                rr = 16'($urandom());
                gg = 16'($urandom());
                bb = 16'($urandom());
            end
        endcase
        frame_valid = 1'b1;
        line_valid  = 1'b1;
        pixel_data  = cur_mode[1] ? {bb, gg, rr} : {rr, gg, bb};
        e.d     = pick(cur_mode, r, c, rr, gg, bb);
        e.first = (r == 0) && (c == 0);
        e.ls    = (c == 0);
        e.last  = (r == cur_rows - 1) && (c == cur_cols - 1);
        e.due   = cyc + 2;
        expq.push_back(e);
        step();
    endtask

    task automatic send_line(input int r, input int n, input int kind);
        for (int c = 0; c < n; c++) drive_px(r, c, kind);
        idle(1, 1'b1);
    endtask

    task automatic send_frame(input int kind);
        idle(1, 1'b1);
        for (int r = 0; r < cur_rows; r++) send_line(r, cur_cols, kind);
        idle(2, 1'b0);
    endtask

    task automatic configure(input int rows, input int cols,
                             input logic [1:0] m);
        c_en         = 1'b0;
        c_rows       = 14'(rows);
        c_cols       = 15'(cols);
        c_bayer_mode = m;
        cur_rows     = rows;
        cur_cols     = cols;
        cur_mode     = m;
        idle(2, 1'b0);
        c_en = 1'b1;
        idle(1, 1'b0);
    endtask

    initial begin
        logic [15:0] ramp_exp [8];
        ramp_exp = '{16'h1000, 16'h2001, 16'h1002, 16'h2003,
                     16'h2004, 16'h3005, 16'h2006, 16'h3007};
        checks = 0; errors = 0; cyc = 0;
        flush_at = -1; fv_clr_at = -1; exp_fv = 1'b0;
        fs_cnt = 0; ls_cnt = 0;
        rst_n = 1'b0; c_en = 1'b0; c_rows = '0; c_cols = '0;
        c_bayer_mode = '0; frame_valid = 1'b0; line_valid = 1'b0;
        pixel_data = '0; err_clr = 1'b0;
        cur_mode = '0; cur_rows = 1; cur_cols = 1;

        step();
        step();
        chk("rst_pixel", pixel_data_o, 16'h0);
        chk("rst_err", err_o, 2'b00);
        rst_n = 1'b1;

        // RGGB ramp with literal expectations
        configure(4, 4, 2'd0);
        seen.delete(); fs_cnt = 0; ls_cnt = 0;
        send_frame(1);
        for (int i = 0; i < 8; i++) chk("ramp_val", seen[i], ramp_exp[i]);
        chk("ramp_fs_cnt", fs_cnt, 1);
        chk("ramp_ls_cnt", ls_cnt, 4);

        // packed swap in BGGR
        configure(2, 2, 2'd3);
        seen.delete();
        send_frame(2);
        chk("swap_00", seen[0], 16'hAAAA);
        chk("swap_11", seen[3], 16'hBBBB);

        configure(2, 2, 2'd1);
        send_frame(0);
        configure(2, 2, 2'd2);
        send_frame(0);

        // short line, then clear
        configure(4, 8, 2'($urandom_range(0, 3)));
        idle(1, 1'b1);
        send_line(0, 8, 0);
        send_line(1, 5, 0);
        chk("short_err", err_o, 2'b01);
        send_line(2, 8, 0);
        send_line(3, 8, 0);
        idle(2, 1'b0);
        chk("short_err_sticky", err_o, 2'b01);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_cleared", err_o, 2'b00);

        // truncation at row 2
        configure(4, 4, 2'($urandom_range(0, 3)));
        idle(1, 1'b1);
        send_line(0, 4, 0);
        send_line(1, 4, 0);
        drive_px(2, 0, 0);
        drive_px(2, 1, 0);
        fv_clr_at = cyc + 2;
        idle(3, 1'b0);
        chk("trunc_err", err_o, 2'b10);
        send_frame(0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("trunc_cleared", err_o, 2'b00);

        // degenerate and random sizes
        configure(1, 4, 2'($urandom_range(0, 3)));
        send_frame(0);
        configure(3, 1, 2'($urandom_range(0, 3)));
        send_frame(0);
        configure(1, 1, 2'($urandom_range(0, 3)));
        send_frame(0);
        for (int k = 0; k < 4; k++) begin
            configure($urandom_range(1, 5), $urandom_range(1, 6),
                      2'($urandom_range(0, 3)));
            send_frame(0);
        end
        chk("degen_err", err_o, 2'b00);

        // enable dropped mid-line, re-enabled with 6 columns
        configure(4, 8, 2'($urandom_range(0, 3)));
        idle(1, 1'b1);
        drive_px(0, 0, 0);
        drive_px(0, 1, 0);
        drive_px(0, 2, 0);
        c_en = 1'b0;
        flush_at = cyc + 1;
        step();
        chk("dis_lv", line_valid_o, 1'b0);
        chk("dis_fv", frame_valid_o, 1'b0);
        frame_valid = 1'b0;
        line_valid  = 1'b0;
        c_cols      = 15'd6;
        c_rows      = 14'd2;
        cur_cols    = 6;
        cur_rows    = 2;
        step();
        step();
        c_en = 1'b1;
        step();
        seen.delete(); ls_cnt = 0; fs_cnt = 0;
        send_frame(0);
        chk("reen_ls_cnt", ls_cnt, 2);
        chk("reen_count", seen.size(), 12);
        chk("reen_err", err_o, 2'b00);

        // async reset mid-frame
        configure(4, 4, 2'($urandom_range(0, 3)));
        idle(1, 1'b1);
        send_line(0, 4, 0);
        send_line(1, 2, 0);
        drive_px(2, 0, 0);
        drive_px(2, 1, 0);
        drive_px(2, 2, 0);
        chk("pre_rst_err", err_o, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_lv", line_valid_o, 1'b0);
        chk("arst_fv", frame_valid_o, 1'b0);
        chk("arst_fs", frame_start_o, 1'b0);
        chk("arst_ls", line_start_o, 1'b0);
        chk("arst_pix", pixel_data_o, 16'h0);
        chk("arst_err", err_o, 2'b00);
        expq.delete();
        exp_fv = 1'b0;
        fv_clr_at = -1;
        idle(2, 1'b0);
        rst_n = 1'b1;
        configure(3, 5, 2'($urandom_range(0, 3)));
        send_frame(0);
        chk("final_err", err_o, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
